// File: rtl/proc_scheduler.sv
// Preemptive round-robin process scheduler: tracks the core owner, the ready set,
// the running quantum and the next round-robin candidate after the last user process.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_OS      | OS (slot 0) owns the core, waiting for a dispatch
// ST_RUN     | user process owns the core, quantum counting down on tick
// ST_PREEMPT | quantum expired, process still owns core until os_ack
module proc_scheduler #(
   parameter int NUM_PROC  = 8,
   parameter int PROC_W    = 6,
   parameter int QUANTUM_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [QUANTUM_W-1:0] quantum,
   input  logic                 proc_swap,
   input  logic [PROC_W-1:0]    new_proc_num,
   input  logic                 true_intrpt,
   input  logic                 proc_exit,
   input  logic                 ready_set,
   input  logic [PROC_W-1:0]    ready_id,
   input  logic                 os_ack,
   output logic [PROC_W-1:0]    exec_proc,
   output logic [PROC_W-1:0]    last_proc,
   output logic [PROC_W-1:0]    next_proc,
   output logic [NUM_PROC-1:0]  ready_mask,
   output logic                 preempt_req,
   output logic                 idle,
   output logic                 swap_err,
   output logic [QUANTUM_W-1:0] slice_left
);

   typedef enum logic [1:0] {
      ST_OS      = 2'd0,
      ST_RUN     = 2'd1,
      ST_PREEMPT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PROC_W-1:0]    exec_q, exec_d;
   logic [PROC_W-1:0]    last_q, last_d;
   logic [NUM_PROC-1:0]  ready_q, ready_d;
   logic [QUANTUM_W-1:0] slice_q, slice_d;
   logic                 preempt_q, preempt_d;
   logic                 swap_err_q, swap_err_d;
   logic                 wrap_q, wrap_d;

   logic                 id_ready;
   logic                 expire;
   logic                 leave_run;
   logic                 clear_en;

   // Slot 0 and out-of-range ids never match, so they always read as not ready.
   always_comb begin
      id_ready = 1'b0;
      for (int i = 1; i < NUM_PROC; i++) begin
         if (new_proc_num == PROC_W'(i) && ready_q[i]) id_ready = 1'b1;
      end
   end

   // wrap_q marks a zero quantum: the first tick is absorbed so all-ones lasts 2^QUANTUM_W ticks.
   assign expire    = tick && !wrap_q && (slice_q == QUANTUM_W'(1));
   assign leave_run = proc_exit || true_intrpt;
   assign clear_en  = proc_exit && (state_q != ST_OS);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_OS;
         exec_q     <= '0;
         last_q     <= '0;
         ready_q    <= '0;
         slice_q    <= '0;
         preempt_q  <= 1'b0;
         swap_err_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         exec_q     <= exec_d;
         last_q     <= last_d;
         ready_q    <= ready_d;
         slice_q    <= slice_d;
         preempt_q  <= preempt_d;
         swap_err_q <= swap_err_d;
         wrap_q     <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OS: begin
            if (proc_swap && id_ready) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (leave_run)   state_d = ST_OS;
            else if (expire) state_d = ST_PREEMPT;
         end
         ST_PREEMPT: begin
            if (proc_exit || os_ack) state_d = ST_OS;
         end
         default: state_d = ST_OS;
      endcase
   end

   always_comb begin
      exec_d     = exec_q;
      last_d     = last_q;
      slice_d    = slice_q;
      preempt_d  = preempt_q;
      wrap_d     = wrap_q;
      swap_err_d = 1'b0;
      case (state_q)
         ST_OS: begin
            if (proc_swap) begin
               if (id_ready) begin
                  exec_d  = new_proc_num;
                  slice_d = (quantum == '0) ? '1 : quantum;
                  wrap_d  = (quantum == '0);
               end else begin
                  swap_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (leave_run) begin
               exec_d  = '0;
               last_d  = exec_q;
               slice_d = '0;
               wrap_d  = 1'b0;
            end else if (tick) begin
               if (wrap_q) begin
                  wrap_d = 1'b0;
               end else if (expire) begin
                  preempt_d = 1'b1;
                  slice_d   = '0;
               end else begin
                  slice_d = slice_q - QUANTUM_W'(1);
               end
            end
         end
         ST_PREEMPT: begin
            if (proc_exit || os_ack) begin
               exec_d    = '0;
               last_d    = exec_q;
               preempt_d = 1'b0;
            end
         end
         default: begin
            exec_d    = '0;
            preempt_d = 1'b0;
            slice_d   = '0;
            wrap_d    = 1'b0;
         end
      endcase
   end

   // Set before clear so an exit of the same id in the same cycle wins.
   always_comb begin
      ready_d = ready_q;
      for (int i = 1; i < NUM_PROC; i++) begin
         if (ready_set && ready_id == PROC_W'(i)) ready_d[i] = 1'b1;
         if (clear_en && exec_q == PROC_W'(i))    ready_d[i] = 1'b0;
      end
      ready_d[0] = 1'b0;
   end

   // Round-robin distance from last_proc; last_proc itself sits at the farthest distance.
   always_comb begin
      int l;
      int d;
      int best;
      int best_d;
      l      = int'(last_q);
      d      = 0;
      best   = 0;
      best_d = NUM_PROC;
      for (int j = 1; j < NUM_PROC; j++) begin
         d = (j > l) ? (j - l) : (j - l + (NUM_PROC - 1));
         if (ready_q[j] && d < best_d) begin
            best_d = d;
            best   = j;
         end
      end
      next_proc = PROC_W'(best);
   end

   assign exec_proc   = exec_q;
   assign last_proc   = last_q;
   assign ready_mask  = ready_q;
   assign preempt_req = preempt_q;
   assign swap_err    = swap_err_q;
   assign slice_left  = slice_q;
   assign idle        = (ready_q == '0);

endmodule

// File: doc/proc_scheduler.md
# proc_scheduler

Parametrised preemptive round-robin process scheduler for the BM_CORE OS datapath, replacing the single-register process keeper. It tracks which process owns the core (process 0 is the OS) and a ready mask of up to NUM_PROC processes. It enforces a time quantum by raising a preemption request to the OS, and computes the next ready process in round-robin order. It sits between the control unit (proc_swap, interruption trigger) and the process decoder/program counter, and drives exec_proc.

## Interface
- NUM_PROC, 8, number of process slots including OS slot 0 (2..64)
- PROC_W, 6, width of process ids (2^PROC_W >= NUM_PROC)
- QUANTUM_W, 16, width of quantum counter
- clk  in  1  single clock (divided core clock); all state changes on rising edge
- rst  in  1  synchronous reset, active-low
- tick  in  1  quantum count enable (one core instruction cycle)
- quantum  in  QUANTUM_W  time slice loaded on dispatch; 0 means 2^QUANTUM_W
- proc_swap  in  1  OS dispatch request, qualified with new_proc_num
- new_proc_num  in  PROC_W  process to dispatch
- true_intrpt  in  1  running process traps to OS (syscall/halt)
- proc_exit  in  1  running process terminates
- ready_set  in  1  mark ready_id ready (loader finished)
- ready_id  in  PROC_W  slot for ready_set
- os_ack  in  1  OS has saved context; completes preemption
- exec_proc  out  PROC_W  process currently owning the core
- last_proc  out  PROC_W  last non-OS process that ran
- next_proc  out  PROC_W  round-robin candidate after last_proc; 0 if none
- ready_mask  out  NUM_PROC  bit i set = process i ready; bit 0 always 0
- preempt_req  out  1  quantum expired, waiting for os_ack
- idle  out  1  no user process ready
- swap_err  out  1  one-cycle pulse: rejected proc_swap
- slice_left  out  QUANTUM_W  remaining quantum of running process

## Operation
- States: OS (exec_proc=0), RUN (user process), PREEMPT (quantum expired, process still owns core until ack).
- OS: proc_swap with new_proc_num in 1..NUM_PROC-1 and ready → RUN, exec_proc=new_proc_num, slice_left=quantum (0 loads all-ones and counts one extra tick, giving 2^QUANTUM_W). Id 0, out of range, or not ready → stay OS, swap_err pulse. Other inputs except ready_set are ignored in OS.
- RUN: each tick decrements slice_left. A tick with slice_left==1 → PREEMPT, preempt_req=1, slice_left=0.
- RUN: true_intrpt → OS, last_proc=exec_proc. proc_exit → OS, last_proc=exec_proc, and the ready bit of that process is cleared.
- PREEMPT: tick is ignored. os_ack → OS, preempt_req=0, last_proc=exec_proc. proc_exit in PREEMPT behaves as in RUN and also clears preempt_req.
- next_proc: the first set ready bit scanning last_proc+1 upward, wrapping past NUM_PROC-1 to 1. last_proc itself is eligible last. If there is none, next_proc=0. Combinational from registered state.
- idle = (ready_mask==0).
- ready_set sets bit ready_id in any state. ready_id 0 or out of range is ignored.
- Priority within a cycle: proc_exit > true_intrpt > quantum expiry. A trap on the expiring tick returns to OS with no preempt_req.
- ready_set and proc_exit targeting the same id in the same cycle: the bit ends cleared.

## Timing
- All outputs registered except next_proc and idle, which are combinational from registers.
- Reset (rst=0 at edge): exec_proc=0, last_proc=0, ready_mask=0, state OS, slice_left=0, preempt_req=0, swap_err=0. As a result, next_proc=0 and idle=1.
- Dispatch latency: 1 cycle from the proc_swap edge to exec_proc valid.
- With quantum=Q, preempt_req rises on the edge of the Q-th tick after dispatch.
- Preemption handshake: preempt_req holds until the os_ack edge. exec_proc=0 in the cycle after os_ack.
- Reset mid-operation discards all state, including a pending preemption.

## Test plan
- Reset, then ready_set ids 3 and 5. proc_swap new=3 with quantum=4 → exec_proc=3 after 1 cycle. After 4 ticks → preempt_req=1. os_ack → exec_proc=0, last_proc=3, next_proc=5.
- Dispatch id 5 with ready_mask={3,5} and last_proc=5 → next_proc wraps to 3. Then proc_exit of 5 and 3 → idle=1, next_proc=0.
- proc_swap new=2 (not ready) → swap_err pulses for 1 cycle, exec_proc stays 0. proc_swap new=0 → same result.
- true_intrpt on the same tick that slice_left goes 1→0 → state OS, preempt_req never asserted, last_proc=running id.
- quantum=0 with QUANTUM_W=4 → preempt after exactly 16 ticks. Ticks in PREEMPT leave slice_left=0.
- Apply rst=0 during PREEMPT with ready_mask≠0 → next cycle all outputs at reset values. ready_set and proc_exit on the same id in one cycle → bit ends cleared.
